// File: rtl/matvec_serial_stream_pkg.sv
// Shared GRU fixed-point constants, accumulator sizing and FSM state encoding.
// No logic; imported by the matvec engine and its MAC.
// No handshake of its own.
package matvec_serial_stream_pkg;

    localparam int GRU_DATA_WIDTH = 8;
    localparam int GRU_FRAC_BITS  = 4;

    typedef enum logic [1:0] {
        S_VEC   = 2'd0,
        S_ROW   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Room for a full row of unsigned products without overflow.
    function automatic int acc_width(input int x, input int dw);
        return 2 * dw + $clog2(x);
    endfunction

endpackage

// File: rtl/matvec_serial_stream_mac_unit.sv
// Single multiplier feeding a registered accumulator; sum is the running total including this beat.
// Latency: sum is combinational, acc updates on the accepting edge.
// No backpressure: the caller gates en with the beat handshake.
module matvec_serial_stream_mac_unit #(
    parameter int DW = 8,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          first,
    input  logic          clr,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] sum
);
    logic [AW-1:0]   acc;
    logic [2*DW-1:0] prod;

    assign prod = (2 * DW)'(a) * (2 * DW)'(b);
    // Column 0 restarts the row, so the previous row's total never leaks in.
    assign sum  = (first ? {AW{1'b0}} : acc) + AW'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matvec_serial_stream.sv
// Serial H x X matrix-vector engine: vector beats, then row-major weights, one result per row.
// Latency: row result valid the cycle after its last weight is accepted.
// Backpressure: only a row's final beat stalls while the previous result is still unaccepted.
module matvec_serial_stream
    import matvec_serial_stream_pkg::*;
#(
    parameter int X          = 4,
    parameter int H          = 4,
    parameter int DATA_WIDTH = GRU_DATA_WIDTH,
    parameter int FRAC_BITS  = GRU_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int AW = acc_width(X, DATA_WIDTH);
    localparam int CW = (X > 1) ? $clog2(X) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] vec [X];
    logic [AW-1:0]         rowsum;
    logic                  beat;
    logic                  col_last;
    logic                  row_last;

    assign beat     = s_valid && s_ready;
    assign col_last = (col == CW'(X - 1));
    assign row_last = (row == RW'(H - 1));

    matvec_serial_stream_mac_unit #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (beat && (state == S_ROW)),
        .first (col == '0),
        .clr   (beat && (state == S_VEC) && col_last),
        .a     (s_data),
        .b     (vec[col]),
        .sum   (rowsum)
    );

    // Next row may accumulate under a pending result; only its closing beat must wait.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n) begin
            case (state)
                S_VEC:   s_ready = 1'b1;
                S_ROW:   s_ready = !(col_last && m_valid && !m_ready);
                default: s_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_VEC;
            col     <= '0;
            row     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            for (int i = 0; i < X; i++) vec[i] <= '0;
        end else begin
            if (m_valid && m_ready) m_valid <= 1'b0;
            case (state)
                S_VEC: begin
                    if (beat) begin
                        vec[col] <= s_data;
                        if (col_last) begin
                            col   <= '0;
                            row   <= '0;
                            state <= S_ROW;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_ROW: begin
                    if (beat) begin
                        if (col_last) begin
                            m_valid <= 1'b1;
                            m_data  <= rowsum[FRAC_BITS+DATA_WIDTH-1 -: DATA_WIDTH];
                            m_last  <= row_last;
                            col     <= '0;
                            if (row_last) begin
                                row   <= '0;
                                state <= S_DRAIN;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (m_valid && m_ready) state <= S_VEC;
                end
                default: state <= S_VEC;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_serial_stream.sv
// Randomized bench for matvec_serial_stream against an arithmetic row-sum model.
module tb_matvec_serial_stream;
    localparam int X    = 4;
    localparam int H    = 4;
    localparam int FRAC = 4;

    typedef logic [7:0] dq_t[$];
    typedef logic       lq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'd0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;

    int checks = 0;
    int failures = 0;
    int fv [X];
    int fw [H][X];

    always #5 clk = ~clk;

    matvec_serial_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    function automatic dq_t build_beats();
        dq_t q;
        q = {};
        for (int c = 0; c < X; c++) q.push_back(8'(fv[c]));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < X; c++) q.push_back(8'(fw[r][c]));
        return q;
    endfunction

    // Row dot product, drop FRAC fractional bits, keep the low byte.
    function automatic dq_t model();
        dq_t q;
        q = {};
        for (int r = 0; r < H; r++) begin
            int s;
            s = 0;
            for (int c = 0; c < X; c++) s += fv[c] * fw[r][c];
            q.push_back(8'((s >> FRAC) % 256));
        end
        return q;
    endfunction

    task automatic run_frame(input dq_t beats, input int vld_pct, input int rdy_pct,
                             input int hold, input int stop_after,
                             output dq_t got_d, output lq_t got_l, output dq_t hold_d,
                             output int stall_min, output int stall_max, output bit timed_out);
        int  idx;
        int  cyc;
        int  left;
        bit  started;
        idx = 0; cyc = 0; left = 0; started = 0;
        got_d = {}; got_l = {}; hold_d = {};
        stall_min = -1; stall_max = -1; timed_out = 0;
        forever begin
            @(negedge clk);
            if (idx >= stop_after || (idx >= beats.size() && got_d.size() >= H)) break;
            if (cyc >= 3000) begin timed_out = 1; break; end
            cyc++;
            s_valid = (idx < beats.size()) && ($urandom_range(99) < vld_pct);
            s_data  = s_valid ? beats[idx] : 8'($urandom);
            if (hold > 0 && m_valid && !started) begin started = 1; left = hold; end
            if (left > 0) begin
                m_ready = 1'b0;
                left--;
                hold_d.push_back(m_data);
            end else begin
                m_ready = ($urandom_range(99) < rdy_pct);
            end
            #1;
            if (s_valid && !s_ready) begin
                if (stall_min < 0) stall_min = idx;
                stall_max = idx;
            end
            if (s_valid && s_ready) idx++;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        checks++; if (m_data !== 8'd0) begin failures++; $display("FAIL reset_m_data got=%0d want=0", m_data); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b want=0", m_last); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL release_s_ready got=%b want=1", s_ready); end
    endtask

    task automatic test_pattern(input string name, input int vld_pct, input int rdy_pct);
        dq_t exp, got_d, hold_d;
        lq_t got_l;
        int  smin, smax;
        bit  to;
        exp = model();
        run_frame(build_beats(), vld_pct, rdy_pct, 0, 1 << 30, got_d, got_l, hold_d, smin, smax, to);
        checks++;
        if (to || got_d.size() != H) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d timeout=%0d", name, got_d.size(), H, to);
        end
        for (int i = 0; i < H && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp[i]) begin
                failures++;
                $display("FAIL %s_data[%0d] got=%0d want=%0d", name, i, got_d[i], exp[i]);
            end
            checks++;
            if (got_l[i] !== (i == H - 1)) begin
                failures++;
                $display("FAIL %s_last[%0d] got=%b want=%b", name, i, got_l[i], i == H - 1);
            end
        end
    endtask

    task automatic test_all16();
        for (int c = 0; c < X; c++) fv[c] = 16;
        for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = 16;
        test_pattern("all16", 100, 100);
    endtask

    task automatic test_identity();
        for (int c = 0; c < X; c++) fv[c] = c + 1;
        for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = (r == c) ? 16 : 0;
        test_pattern("identity", 100, 100);
    endtask

    task automatic test_wrap();
        for (int c = 0; c < X; c++) fv[c] = 255;
        for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = 255;
        test_pattern("wrap", 100, 100);
    endtask

    task automatic test_backpressure();
        dq_t exp, got_d, hold_d;
        lq_t got_l;
        int  smin, smax;
        bit  to;
        for (int c = 0; c < X; c++) fv[c] = 16;
        for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = r + 1;
        exp = model();
        run_frame(build_beats(), 100, 100, 10, 1 << 30, got_d, got_l, hold_d, smin, smax, to);
        checks++;
        if (hold_d.size() != 10) begin
            failures++;
            $display("FAIL bp_hold_len got=%0d want=10", hold_d.size());
        end
        for (int i = 0; i < hold_d.size(); i++) begin
            checks++;
            if (hold_d[i] !== exp[0]) begin
                failures++;
                $display("FAIL bp_hold_data[%0d] got=%0d want=%0d", i, hold_d[i], exp[0]);
            end
        end
        // Row 1's closing beat is the only one that may wait.
        checks++;
        if (smin != 3 * X - 1 || smax != 3 * X - 1) begin
            failures++;
            $display("FAIL bp_stall_beat got=%0d..%0d want=%0d", smin, smax, 3 * X - 1);
        end
        checks++;
        if (to || got_d.size() != H) begin
            failures++;
            $display("FAIL bp_count got=%0d want=%0d timeout=%0d", got_d.size(), H, to);
        end
        for (int i = 0; i < H && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp[i] || got_l[i] !== (i == H - 1)) begin
                failures++;
                $display("FAIL bp_result[%0d] got=%0d/%b want=%0d/%b", i, got_d[i], got_l[i], exp[i], i == H - 1);
            end
        end
    endtask

    task automatic test_random();
        dq_t exp, got_d, hold_d;
        lq_t got_l;
        int  smin, smax;
        bit  to;
        for (int f = 0; f < 100; f++) begin
            for (int c = 0; c < X; c++) fv[c] = $urandom_range(255);
            for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = $urandom_range(255);
            exp = model();
            run_frame(build_beats(), 50, 50, 0, 1 << 30, got_d, got_l, hold_d, smin, smax, to);
            checks++;
            if (to || got_d.size() != H) begin
                failures++;
                $display("FAIL rand_count frame=%0d got=%0d want=%0d timeout=%0d", f, got_d.size(), H, to);
            end
            for (int i = 0; i < H && i < got_d.size(); i++) begin
                checks++;
                if (got_d[i] !== exp[i] || got_l[i] !== (i == H - 1)) begin
                    failures++;
                    $display("FAIL rand_result frame=%0d row=%0d got=%0d/%b want=%0d/%b",
                             f, i, got_d[i], got_l[i], exp[i], i == H - 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        dq_t got_d, hold_d;
        lq_t got_l;
        int  smin, smax;
        bit  to;
        for (int c = 0; c < X; c++) fv[c] = $urandom_range(255);
        for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = $urandom_range(255);
        run_frame(build_beats(), 100, 100, 0, X + 2 * X + 2, got_d, got_l, hold_d, smin, smax, to);
        checks++;
        if (to) begin failures++; $display("FAIL midrst_prefix got=timeout want=accepted"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid got=%b want=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL midrst_s_ready got=%b want=0", s_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < X; c++) fv[c] = 16;
        for (int r = 0; r < H; r++) for (int c = 0; c < X; c++) fw[r][c] = 16;
        test_pattern("after_rst", 100, 100);
    endtask

    initial begin
        test_reset();
        test_all16();
        test_identity();
        test_wrap();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
